sc_selftest_ctrl: RTL and testbench

SC_SELFTEST_CTRL -- requirements
Module: sc_selftest_ctrl

---
 rtl/sc_selftest_pkg.sv | 31 +++
 rtl/sc_selftest_golden.sv | 30 +++
 rtl/sc_selftest_ctrl.sv | 141 ++++++++++++++
 tb/tb_sc_selftest_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_selftest_pkg.sv
// Shared types and constants for the standard-cell self-test controller.
package sc_selftest_pkg;

    localparam int unsigned VEC_W = 3;
    localparam int unsigned OBS_W = 9;
    localparam int unsigned CNT_W = 4;

    // Bit positions of each cell output within OBS and the expected vector.
    localparam int unsigned OBS_INV    = 0;
    localparam int unsigned OBS_NAND2  = 1;
    localparam int unsigned OBS_NAND2B = 2;
    localparam int unsigned OBS_AND2   = 3;
    localparam int unsigned OBS_NOR2   = 4;
    localparam int unsigned OBS_NOR2B  = 5;
    localparam int unsigned OBS_OR2    = 6;
    localparam int unsigned OBS_BUFF   = 7;
    localparam int unsigned OBS_MUX2   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sc_selftest_golden.sv
// Combinational golden model: stimulus {S,B,A} -> expected cell-bank outputs.
module sc_selftest_golden
    import sc_selftest_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic [OBS_W-1:0] exp_o
);

    logic a;
    logic b;
    logic s;

    assign a = vec_i[0];
    assign b = vec_i[1];
    assign s = vec_i[2];

    always_comb begin
        exp_o             = '0;
        exp_o[OBS_INV]    = ~a;
        exp_o[OBS_NAND2]  = ~(a & b);
        exp_o[OBS_NAND2B] = ~(~a & b);
        exp_o[OBS_AND2]   = a & b;
        exp_o[OBS_NOR2]   = ~(a | b);
        exp_o[OBS_NOR2B]  = ~(~a | b);
        exp_o[OBS_OR2]    = a | b;
        exp_o[OBS_BUFF]   = a;
        exp_o[OBS_MUX2]   = s ? b : a;
    end

endmodule

// File: rtl/sc_selftest_ctrl.sv
// Self-test sequencer: sweeps all eight {S,B,A} vectors through a cell bank,
// compares the observed outputs against the golden model and records results.
module sc_selftest_ctrl
    import sc_selftest_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             START,
    input  logic [OBS_W-1:0] OBS,
    output logic             DUT_A,
    output logic             DUT_B,
    output logic             DUT_S,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [VEC_W-1:0] FAIL_VEC,
    output logic [OBS_W-1:0] FAIL_MASK,
    output logic [CNT_W-1:0] ERR_COUNT
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] fvec_q, fvec_d;
    logic [OBS_W-1:0] fmask_q, fmask_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic [OBS_W-1:0] expected;
    logic [OBS_W-1:0] diff;
    logic             mismatch;

    sc_selftest_golden u_golden (
        .vec_i (vec_q),
        .exp_o (expected)
    );

    assign diff     = expected ^ OBS;
    assign mismatch = |diff;

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fmask_q  <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fmask_q  <= fmask_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SETTLE;
            ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK: begin
                if (vec_q == '1 || (mismatch && STOP_ON_FAIL)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The vector counter doubles as the stimulus register, so DUT inputs only
    // move on the edges that enter DRIVE (sweep start or CHECK -> DRIVE).
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fmask_d  = fmask_q;
        done_d   = done_q;
        pass_d   = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    vec_d   = '0;
                    err_d   = '0;
                    fvec_d  = '0;
                    fmask_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE:  settle_d = '0;
            ST_SETTLE: settle_d = settle_q + 1'b1;
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    if (err_q == '0) begin
                        fvec_d  = vec_q;
                        fmask_d = diff;
                    end
                end
                if (state_d == ST_FINISH) begin
                    done_d = 1'b1;
                    pass_d = (err_d == '0);
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        BUSY      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        DUT_A     = vec_q[0];
        DUT_B     = vec_q[1];
        DUT_S     = vec_q[2];
        DONE      = done_q;
        PASS      = pass_q;
        FAIL_VEC  = fvec_q;
        FAIL_MASK = fmask_q;
        ERR_COUNT = err_q;
    end

endmodule

// File: tb/tb_sc_selftest_ctrl.sv
// Bench for sc_selftest_ctrl: three parameterisations driven by a modelled
// cell bank with injectable stuck-at-0 and inversion faults.
module tb_sc_selftest_ctrl;

    localparam int SET  [3] = '{2, 2, 15};
    localparam bit STOP [3] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start [3];
    logic [8:0] obs   [3];
    logic       da    [3];
    logic       db    [3];
    logic       ds    [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [2:0] fvec  [3];
    logic [8:0] fmask [3];
    logic [3:0] errc  [3];
    logic [8:0] stuck [3];
    logic [8:0] flip  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_expect(input logic [2:0] v);
        int a, b, s;
        logic [8:0] e;
        a = int'(v[0]);
        b = int'(v[1]);
        s = int'(v[2]);
        e[0] = (a == 0);
        e[1] = !(a == 1 && b == 1);
        e[2] = !(a == 0 && b == 1);
        e[3] = (a == 1 && b == 1);
        e[4] = (a == 0 && b == 0);
        e[5] = (a == 1 && b == 0);
        e[6] = (a == 1 || b == 1);
        e[7] = (a == 1);
        e[8] = (s == 1) ? (b == 1) : (a == 1);
        return e;
    endfunction

    function automatic logic [8:0] cell_bank(input int k, input logic [2:0] v);
        return (ref_expect(v) & ~stuck[k]) ^ flip[k];
    endfunction

    assign obs[0] = cell_bank(0, {ds[0], db[0], da[0]});
    assign obs[1] = cell_bank(1, {ds[1], db[1], da[1]});
    assign obs[2] = cell_bank(2, {ds[2], db[2], da[2]});

    sc_selftest_ctrl #(.SETTLE_CYCLES(SET[0]), .STOP_ON_FAIL(STOP[0])) u_dut0 (
        .CLK(clk), .RESET_B(rst_b), .START(start[0]), .OBS(obs[0]),
        .DUT_A(da[0]), .DUT_B(db[0]), .DUT_S(ds[0]), .BUSY(busy[0]), .DONE(done[0]),
        .PASS(pass[0]), .FAIL_VEC(fvec[0]), .FAIL_MASK(fmask[0]), .ERR_COUNT(errc[0]));

    sc_selftest_ctrl #(.SETTLE_CYCLES(SET[1]), .STOP_ON_FAIL(STOP[1])) u_dut1 (
        .CLK(clk), .RESET_B(rst_b), .START(start[1]), .OBS(obs[1]),
        .DUT_A(da[1]), .DUT_B(db[1]), .DUT_S(ds[1]), .BUSY(busy[1]), .DONE(done[1]),
        .PASS(pass[1]), .FAIL_VEC(fvec[1]), .FAIL_MASK(fmask[1]), .ERR_COUNT(errc[1]));

    sc_selftest_ctrl #(.SETTLE_CYCLES(SET[2]), .STOP_ON_FAIL(STOP[2])) u_dut2 (
        .CLK(clk), .RESET_B(rst_b), .START(start[2]), .OBS(obs[2]),
        .DUT_A(da[2]), .DUT_B(db[2]), .DUT_S(ds[2]), .BUSY(busy[2]), .DONE(done[2]),
        .PASS(pass[2]), .FAIL_VEC(fvec[2]), .FAIL_MASK(fmask[2]), .ERR_COUNT(errc[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the eight vectors the way the sweep is described: mismatch counting,
    // first-failure capture and optional early stop.
    task automatic predict(input int k, output int e_err, output int e_fvec,
                           output int e_fmask, output int e_len);
        int nvec;
        e_err = 0; e_fvec = 0; e_fmask = 0; nvec = 8;
        for (int v = 0; v < 8; v++) begin
            logic [8:0] m;
            m = ref_expect(3'(v)) ^ cell_bank(k, 3'(v));
            if (m != 0) begin
                if (e_err == 0) begin
                    e_fvec  = v;
                    e_fmask = int'(m);
                end
                if (e_err < 15) e_err++;
                if (STOP[k]) begin
                    nvec = v + 1;
                    break;
                end
            end
        end
        e_len = nvec * (SET[k] + 2);
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("rst%0d_dut", k), {ds[k], db[k], da[k]}, 0);
        chk($sformatf("rst%0d_busy", k), busy[k], 0);
        chk($sformatf("rst%0d_done", k), done[k], 0);
        chk($sformatf("rst%0d_pass", k), pass[k], 0);
        chk($sformatf("rst%0d_fvec", k), fvec[k], 0);
        chk($sformatf("rst%0d_fmask", k), fmask[k], 0);
        chk($sformatf("rst%0d_err", k), errc[k], 0);
    endtask

    task automatic begin_sweep(input int k, input string tag, input bit hold);
        start[k] = 1'b1;
        tick();
        if (!hold) start[k] = 1'b0;
        chk({tag, ":busy_on"}, busy[k], 1);
        chk({tag, ":done_clr"}, done[k], 0);
        chk({tag, ":err_clr"}, errc[k], 0);
    endtask

    // Entered on the first DRIVE cycle; leaves one cycle into IDLE.
    task automatic sweep_body(input int k, input string tag, input bit pulse_mid);
        int e_err, e_fvec, e_fmask, e_len, c, pulse_at;
        predict(k, e_err, e_fvec, e_fmask, e_len);
        pulse_at = $urandom_range(1, e_len - 2);
        c = 0;
        while (busy[k] && c < e_len + 20) begin
            chk({tag, ":vec"}, {ds[k], db[k], da[k]}, c / (SET[k] + 2));
            if (pulse_mid) start[k] = (c == pulse_at);
            c++;
            tick();
        end
        if (pulse_mid) start[k] = 1'b0;
        chk({tag, ":len"}, c, e_len);
        chk({tag, ":done"}, done[k], 1);
        chk({tag, ":pass"}, pass[k], (e_err == 0) ? 1 : 0);
        chk({tag, ":err"}, errc[k], e_err);
        chk({tag, ":fvec"}, fvec[k], e_fvec);
        chk({tag, ":fmask"}, fmask[k], e_fmask);
        tick();
        chk({tag, ":done_hold"}, done[k], 1);
        chk({tag, ":idle"}, busy[k], 0);
    endtask

    initial begin
        rst_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            stuck[k] = '0;
            flip[k]  = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) chk_reset(k);
        rst_b = 1'b1;
        tick();

        // Clean sweep, default parameters: 32 busy cycles, PASS.
        begin_sweep(0, "clean", 1'b0);
        sweep_body(0, "clean", 1'b0);

        // and2 output stuck at 0: fails at vectors 3 and 7.
        stuck[0] = 9'h008;
        begin_sweep(0, "and_stuck", 1'b0);
        sweep_body(0, "and_stuck", 1'b0);
        chk("and_stuck:fvec3", fvec[0], 3);
        chk("and_stuck:mask8", fmask[0], 9'h008);
        stuck[0] = '0;

        // Same fault with early stop.
        stuck[1] = 9'h008;
        begin_sweep(1, "stop", 1'b0);
        sweep_body(1, "stop", 1'b0);
        chk("stop:err1", errc[1], 1);
        stuck[1] = '0;

        // Reset during SETTLE of vector 5, then a fresh clean sweep.
        begin_sweep(0, "abort", 1'b0);
        repeat (21) tick();
        chk("abort:in_settle5", {ds[0], db[0], da[0]}, 5);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk_reset(0);
        tick();
        begin_sweep(0, "after_rst", 1'b0);
        sweep_body(0, "after_rst", 1'b0);

        // START pulsed mid-sweep must not restart it.
        begin_sweep(0, "pulse", 1'b0);
        sweep_body(0, "pulse", 1'b1);

        // START held high: back-to-back sweeps, DONE cleared on the restart.
        begin_sweep(0, "hold1", 1'b1);
        sweep_body(0, "hold1", 1'b0);
        tick();
        chk("hold2:busy_on", busy[0], 1);
        chk("hold2:done_clr", done[0], 0);
        start[0] = 1'b0;
        sweep_body(0, "hold2", 1'b0);

        // Every output inverted.
        flip[0] = 9'h1FF;
        begin_sweep(0, "invert", 1'b0);
        sweep_body(0, "invert", 1'b0);
        chk("invert:err8", errc[0], 8);
        chk("invert:mask", fmask[0], 9'h1FF);
        flip[0] = '0;

        // Longest settle: 136-cycle sweep.
        begin_sweep(2, "slow", 1'b0);
        sweep_body(2, "slow", 1'b0);

        // Random sparse fault patterns on random instances.
        for (int r = 0; r < 8; r++) begin
            int k;
            k = $urandom_range(0, 2);
            stuck[k] = 9'($urandom & $urandom & $urandom);
            flip[k]  = 9'($urandom & $urandom & $urandom);
            begin_sweep(k, $sformatf("rand%0d", r), 1'b0);
            sweep_body(k, $sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
            stuck[k] = '0;
            flip[k]  = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
